// File: rtl/riscv_pkg.sv
// Shared RV64 decode constants: opcodes, ALU_Op encodings and control-bundle bit positions.
package riscv_pkg;

   // Major opcodes, instr[6:0]
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_R      = 7'b0110011;

   // ALU_Op encodings handed to the ALU control unit
   localparam logic [1:0] ALU_OP_ADD    = 2'b00;  // loads/stores: address add
   localparam logic [1:0] ALU_OP_BRANCH = 2'b01;  // branches: subtract/compare
   localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;  // decode from funct3/funct7

   // ctrl_in = {alu_op[1:0],alu_src,reg_write,mem_read,mem_write,mem_to_reg,branch}
   localparam int CI_BRANCH     = 0;
   localparam int CI_MEM_TO_REG = 1;
   localparam int CI_MEM_WRITE  = 2;
   localparam int CI_MEM_READ   = 3;
   localparam int CI_REG_WRITE  = 4;
   localparam int CI_ALU_SRC    = 5;
   localparam int CI_ALU_OP_LO  = 6;

   // ctrl_out = {reg_write,mem_read,mem_write,mem_to_reg,branch,alu_src}
   localparam int CO_ALU_SRC    = 0;
   localparam int CO_BRANCH     = 1;
   localparam int CO_MEM_TO_REG = 2;
   localparam int CO_MEM_WRITE  = 3;
   localparam int CO_MEM_READ   = 4;
   localparam int CO_REG_WRITE  = 5;

   // Reorders the control-unit bundle into the EX-stage bundle (alu_op travels separately)
   function automatic logic [5:0] pack_ctrl_out(input logic [7:0] ci);
      logic [5:0] co;
      co                = '0;
      co[CO_ALU_SRC]    = ci[CI_ALU_SRC];
      co[CO_BRANCH]     = ci[CI_BRANCH];
      co[CO_MEM_TO_REG] = ci[CI_MEM_TO_REG];
      co[CO_MEM_WRITE]  = ci[CI_MEM_WRITE];
      co[CO_MEM_READ]   = ci[CI_MEM_READ];
      co[CO_REG_WRITE]  = ci[CI_REG_WRITE];
      return co;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the I/S/B immediate by opcode and sign-extends from instr[31].
module imm_gen
   import riscv_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [31:0]       instr,
   output logic [DATA_W-1:0] imm
);

   // rs1/funct3 bits never contribute to an immediate of the supported formats
   logic unused_bits;
   assign unused_bits = ^instr[19:12];

   // Opcode-selected immediate; unsupported formats yield zero
   always_comb begin
      imm = '0;
      unique case (instr[6:0])
         OP_LOAD, OP_IMM: imm = {{(DATA_W-12){instr[31]}}, instr[31:20]};
         OP_STORE:        imm = {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]};
         OP_BRANCH:       imm = {{(DATA_W-13){instr[31]}}, instr[31], instr[7],
                                 instr[30:25], instr[11:8], 1'b0};
         default:         imm = '0;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with immediate generation, valid/ready handshake, stall and flush.
// Optional EX-stage operand forwarding is compiled in when FORWARDING_EN is defined.
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [31:0]       instr,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] rs1_data,
   input  logic [DATA_W-1:0] rs2_data,
   input  logic [7:0]        ctrl_in,
`ifdef FORWARDING_EN
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [DATA_W-1:0] store_data,
   output logic [DATA_W-1:0] imm_out,
   output logic [DATA_W-1:0] pc_out,
   output logic [1:0]        alu_op,
   output logic              funct7_b,
   output logic [2:0]        funct3,
   output logic [REG_AW-1:0] rd,
   output logic [REG_AW-1:0] rs1,
   output logic [REG_AW-1:0] rs2,
   output logic [5:0]        ctrl_out
);

   logic              valid_reg;
   logic              valid_next;
   logic              load;
   logic [DATA_W-1:0] imm_next;
   logic [DATA_W-1:0] pc_reg;
   logic [DATA_W-1:0] rs1_val_reg;
   logic [DATA_W-1:0] rs2_val_reg;
   logic [DATA_W-1:0] imm_reg;
   logic [1:0]        alu_op_reg;
   logic              funct7_reg;
   logic [2:0]        funct3_reg;
   logic [REG_AW-1:0] rd_reg;
   logic [REG_AW-1:0] rs1_reg;
   logic [REG_AW-1:0] rs2_reg;
   logic [5:0]        ctrl_reg;
   logic [DATA_W-1:0] rs1_opnd;
   logic [DATA_W-1:0] rs2_opnd;

   imm_gen #(.DATA_W(DATA_W)) u_imm_gen (
      .instr (instr),
      .imm   (imm_next)
   );

   // A stalled stage (valid and not drained) refuses new work; flush always empties it
   assign in_ready   = !valid_reg || out_ready;
   assign load       = in_valid && in_ready;
   assign valid_next = flush ? 1'b0 : (in_ready ? in_valid : 1'b1);

   // Pipeline register: payload captured only on an accepted instruction, held otherwise
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg   <= 1'b0;
         pc_reg      <= '0;
         rs1_val_reg <= '0;
         rs2_val_reg <= '0;
         imm_reg     <= '0;
         alu_op_reg  <= '0;
         funct7_reg  <= 1'b0;
         funct3_reg  <= '0;
         rd_reg      <= '0;
         rs1_reg     <= '0;
         rs2_reg     <= '0;
         ctrl_reg    <= '0;
      end else begin
         valid_reg <= valid_next;
         if (load) begin
            pc_reg      <= pc_in;
            rs1_val_reg <= rs1_data;
            rs2_val_reg <= rs2_data;
            imm_reg     <= imm_next;
            alu_op_reg  <= ctrl_in[CI_ALU_OP_LO+1:CI_ALU_OP_LO];
            funct7_reg  <= instr[30];
            funct3_reg  <= instr[14:12];
            rd_reg      <= instr[11:7];
            rs1_reg     <= instr[19:15];
            rs2_reg     <= instr[24:20];
            ctrl_reg    <= pack_ctrl_out(ctrl_in);
         end
      end
   end

`ifdef FORWARDING_EN
   // Operand bypass: the younger EX/MEM result wins over MEM/WB; x0 is never bypassed
   always_comb begin
      rs1_opnd = rs1_val_reg;
      rs2_opnd = rs2_val_reg;
      if (valid_reg) begin
         if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_reg))
            rs1_opnd = exmem_result;
         else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_reg))
            rs1_opnd = memwb_result;
         if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_reg))
            rs2_opnd = exmem_result;
         else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_reg))
            rs2_opnd = memwb_result;
      end
   end
`else
   // Without bypassing the operands are the captured register-file values
   always_comb begin
      rs1_opnd = rs1_val_reg;
      rs2_opnd = rs2_val_reg;
   end
`endif

   assign out_valid  = valid_reg;
   assign alu_in1    = rs1_opnd;
   assign alu_in2    = ctrl_reg[CO_ALU_SRC] ? imm_reg : rs2_opnd;
   assign store_data = rs2_opnd;
   assign imm_out    = imm_reg;
   assign pc_out     = pc_reg;
   assign alu_op     = alu_op_reg;
   assign funct7_b   = funct7_reg;
   assign funct3     = funct3_reg;
   assign rd         = rd_reg;
   assign rs1        = rs1_reg;
   assign rs2        = rs2_reg;
   // A bubble must never carry write/memory side effects into EX
   assign ctrl_out   = valid_reg ? ctrl_reg : 6'b0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage; define FORWARDING_EN to also exercise operand bypass.
module tb_id_ex_stage;

   localparam int DATA_W = 64;
   localparam int REG_AW = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic              flush;
   logic [31:0]       instr;
   logic [DATA_W-1:0] pc_in;
   logic [DATA_W-1:0] rs1_data;
   logic [DATA_W-1:0] rs2_data;
   logic [7:0]        ctrl_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] alu_in1;
   logic [DATA_W-1:0] alu_in2;
   logic [DATA_W-1:0] store_data;
   logic [DATA_W-1:0] imm_out;
   logic [DATA_W-1:0] pc_out;
   logic [1:0]        alu_op;
   logic              funct7_b;
   logic [2:0]        funct3;
   logic [REG_AW-1:0] rd;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic [5:0]        ctrl_out;
`ifdef FORWARDING_EN
   logic              exmem_reg_write;
   logic [REG_AW-1:0] exmem_rd;
   logic [DATA_W-1:0] exmem_result;
   logic              memwb_reg_write;
   logic [REG_AW-1:0] memwb_rd;
   logic [DATA_W-1:0] memwb_result;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .flush      (flush),
      .instr      (instr),
      .pc_in      (pc_in),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .ctrl_in    (ctrl_in),
`ifdef FORWARDING_EN
      .exmem_reg_write (exmem_reg_write),
      .exmem_rd        (exmem_rd),
      .exmem_result    (exmem_result),
      .memwb_reg_write (memwb_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_result    (memwb_result),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .store_data (store_data),
      .imm_out    (imm_out),
      .pc_out     (pc_out),
      .alu_op     (alu_op),
      .funct7_b   (funct7_b),
      .funct3     (funct3),
      .rd         (rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .ctrl_out   (ctrl_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset must win over a pending valid input and clear every field
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b1;
      instr = 32'hFFC08293; pc_in = 64'h1000; rs1_data = 64'h99; rs2_data = 64'h77;
      ctrl_in = 8'h3F;
`ifdef FORWARDING_EN
      exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
      memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
`endif
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (ctrl_out !== 6'b0) begin errors++; $display("FAIL reset_ctrl_out got=%b exp=000000", ctrl_out); end
      checks++; if (alu_in1 !== 64'd0 || alu_in2 !== 64'd0) begin errors++; $display("FAIL reset_alu_in got=%h/%h exp=0/0", alu_in1, alu_in2); end
      checks++; if (imm_out !== 64'd0 || pc_out !== 64'd0 || rd !== 5'd0) begin errors++; $display("FAIL reset_fields imm=%h pc=%h rd=%0d exp=0", imm_out, pc_out, rd); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      $display("reset: out_valid=%b ctrl_out=%b in_ready=%b", out_valid, ctrl_out, in_ready);
      rst_n = 1'b1; in_valid = 1'b0;
   endtask

   // addi x5,x1,-4: I-immediate negative, selected as operand 2
   task automatic test_addi();
      in_valid = 1'b1; instr = 32'hFFC08293; pc_in = 64'h2000; rs1_data = 64'd10; rs2_data = 64'h1234;
      ctrl_in = 8'h30;   // alu_src=1, reg_write=1
      tick();
      checks++; if (alu_in1 !== 64'd10) begin errors++; $display("FAIL addi_alu_in1 got=%h exp=a", alu_in1); end
      checks++; if (alu_in2 !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL addi_alu_in2 got=%h exp=fffffffffffffffc", alu_in2); end
      checks++; if (funct3 !== 3'b000 || rd !== 5'd5 || rs1 !== 5'd1) begin errors++; $display("FAIL addi_fields funct3=%b rd=%0d rs1=%0d exp=000/5/1", funct3, rd, rs1); end
      checks++; if (out_valid !== 1'b1 || ctrl_out !== 6'b100001) begin errors++; $display("FAIL addi_valid_ctrl valid=%b ctrl=%b exp=1/100001", out_valid, ctrl_out); end
      checks++; if (pc_out !== 64'h2000) begin errors++; $display("FAIL addi_pc got=%h exp=2000", pc_out); end
      $display("addi: alu_in1=%h alu_in2=%h rd=%0d", alu_in1, alu_in2, rd);
   endtask

   // sd x2,8(x1): S-immediate, store data from rs2
   task automatic test_store();
      instr = 32'h0020B423; rs1_data = 64'h100; rs2_data = 64'hAB; ctrl_in = 8'h24;  // alu_src, mem_write
      tick();
      checks++; if (imm_out !== 64'd8) begin errors++; $display("FAIL sd_imm got=%h exp=8", imm_out); end
      checks++; if (store_data !== 64'hAB) begin errors++; $display("FAIL sd_store_data got=%h exp=ab", store_data); end
      checks++; if (ctrl_out !== 6'b001001) begin errors++; $display("FAIL sd_ctrl got=%b exp=001001", ctrl_out); end
      checks++; if (funct3 !== 3'b011 || alu_in2 !== 64'd8 || rs2 !== 5'd2) begin errors++; $display("FAIL sd_fields funct3=%b alu_in2=%h rs2=%0d exp=011/8/2", funct3, alu_in2, rs2); end
      $display("sd: imm=%h store_data=%h ctrl=%b", imm_out, store_data, ctrl_out);
   endtask

   // Downstream stall holds the sd; a waiting add loads once released
   task automatic test_stall();
      out_ready = 1'b0; instr = 32'h002081B3; rs1_data = 64'h11; rs2_data = 64'h22; ctrl_in = 8'h90;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || rd !== 5'd8 || funct3 !== 3'b011 || store_data !== 64'hAB || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold_%0d valid=%b rd=%0d funct3=%b sdata=%h rdy=%b exp=1/8/011/ab/0",
                     i, out_valid, rd, funct3, store_data, in_ready);
         end
         $display("stall %0d: rd=%0d in_ready=%b", i, rd, in_ready);
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
      tick();
      checks++; if (rd !== 5'd3 || funct3 !== 3'b000 || alu_in2 !== 64'h22 || alu_op !== 2'b10) begin errors++; $display("FAIL release_load rd=%0d funct3=%b alu_in2=%h alu_op=%b exp=3/000/22/10", rd, funct3, alu_in2, alu_op); end
      checks++; if (imm_out !== 64'd0 || funct7_b !== 1'b0 || ctrl_out !== 6'b100000) begin errors++; $display("FAIL release_rtype imm=%h f7=%b ctrl=%b exp=0/0/100000", imm_out, funct7_b, ctrl_out); end
      $display("release: rd=%0d alu_in2=%h", rd, alu_in2);
   endtask

   // Flush with a valid incoming sub: bubble, no control side effects
   task automatic test_flush();
      flush = 1'b1; in_valid = 1'b1; instr = 32'h402081B3; ctrl_in = 8'h90;
      tick();
      checks++; if (out_valid !== 1'b0 || ctrl_out !== 6'b0) begin errors++; $display("FAIL flush valid=%b ctrl=%b exp=0/000000", out_valid, ctrl_out); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
      $display("flush: out_valid=%b ctrl_out=%b", out_valid, ctrl_out);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", out_valid); end
      out_ready = 1'b1;
   endtask

   // beq then sub on consecutive cycles: B-immediate and funct7 bit
   task automatic test_back_to_back();
      in_valid = 1'b1; instr = 32'hFE208CE3; rs1_data = 64'h5; rs2_data = 64'h6; ctrl_in = 8'h41;  // branch
      tick();
      checks++; if (imm_out !== 64'hFFFF_FFFF_FFFF_FFF8 || ctrl_out !== 6'b000010 || alu_op !== 2'b01) begin errors++; $display("FAIL beq imm=%h ctrl=%b alu_op=%b exp=fffffffffffffff8/000010/01", imm_out, ctrl_out, alu_op); end
      $display("beq: imm=%h", imm_out);
      instr = 32'h402081B3; ctrl_in = 8'h90; rs1_data = 64'h33; rs2_data = 64'h44;
      tick();
      checks++; if (funct7_b !== 1'b1 || imm_out !== 64'd0 || alu_in1 !== 64'h33 || alu_in2 !== 64'h44) begin errors++; $display("FAIL sub f7=%b imm=%h in1=%h in2=%h exp=1/0/33/44", funct7_b, imm_out, alu_in1, alu_in2); end
      $display("sub: funct7_b=%b alu_in1=%h alu_in2=%h", funct7_b, alu_in1, alu_in2);
      in_valid = 1'b0;
      tick();
   endtask

`ifdef FORWARDING_EN
   // Bypass priority: EX/MEM over MEM/WB over register value; x0 never forwarded
   task automatic test_forwarding();
      in_valid = 1'b1; instr = 32'h002081B3; rs1_data = 64'h11; rs2_data = 64'h22; ctrl_in = 8'h90;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_result = 64'h55;
      memwb_reg_write = 1'b1; memwb_rd = 5'd1; memwb_result = 64'h66;
      #1;
      checks++; if (alu_in1 !== 64'h55) begin errors++; $display("FAIL fwd_exmem got=%h exp=55", alu_in1); end
      exmem_rd = 5'd0;
      #1;
      checks++; if (alu_in1 !== 64'h66) begin errors++; $display("FAIL fwd_memwb got=%h exp=66", alu_in1); end
      exmem_rd = 5'd2;
      #1;
      checks++; if (alu_in2 !== 64'h55 || store_data !== 64'h55) begin errors++; $display("FAIL fwd_rs2 in2=%h sdata=%h exp=55/55", alu_in2, store_data); end
      $display("fwd: alu_in1=%h alu_in2=%h", alu_in1, alu_in2);
      out_ready = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
      in_valid = 1'b1; instr = 32'h00000293; rs1_data = 64'h77; ctrl_in = 8'h30;  // addi x5,x0,0
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (alu_in1 !== 64'h77) begin errors++; $display("FAIL fwd_x0 got=%h exp=77", alu_in1); end
      $display("fwd x0: alu_in1=%h", alu_in1);
   endtask
`endif

   initial begin
      test_reset();
      test_addi();
      test_store();
      test_stall();
      test_flush();
      test_back_to_back();
`ifdef FORWARDING_EN
      test_forwarding();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
